// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a shared 8-to-1 mux: walks the unmasked channels, samples each
// after a settle dwell, and publishes an atomic snapshot plus change mask.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] mask,
  output logic [2:0] mux_sel,
  output logic       mux_enable_n,
  input  logic       mux_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] snapshot,
  output logic [7:0] changed
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, DWELL, FINISH} state_t;

  state_t     state_reg, state_next;
  logic [2:0] sel_reg, sel_next;
  logic       en_n_reg, en_n_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic [7:0] snapshot_reg, snapshot_next;
  logic [7:0] changed_reg, changed_next;
  logic [7:0] shadow_reg, shadow_next;
  logic [7:0] mask_q_reg, mask_q_next;
  logic [3:0] cnt_reg, cnt_next;

  logic       first_valid, next_valid;
  logic [2:0] first_ch, next_ch;

  // First channel comes from the live mask (mask_q is being loaded on the same edge);
  // subsequent channels come from the latched mask.
  always_comb begin
    first_valid = 1'b0;
    first_ch    = 3'd0;
    next_valid  = 1'b0;
    next_ch     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!mask[i]) begin
        first_valid = 1'b1;
        first_ch    = 3'(i);
      end
      if (!mask_q_reg[i] && (i > int'(sel_reg))) begin
        next_valid = 1'b1;
        next_ch    = 3'(i);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    en_n_next     = en_n_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    snapshot_next = snapshot_reg;
    changed_next  = changed_reg;
    shadow_next   = shadow_reg;
    mask_q_next   = mask_q_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      IDLE, FINISH: begin
        en_n_next = 1'b1;
        busy_next = 1'b0;
        if (state_reg == FINISH) begin
          snapshot_next = shadow_reg;
          changed_next  = (shadow_reg ^ snapshot_reg) & ~mask_q_reg;
          state_next    = IDLE;
        end
        if (start && !abort) begin
          // Seed from the snapshot as it will be after this edge, so back-to-back
          // scans compare against the scan that just finished.
          mask_q_next = mask;
          shadow_next = snapshot_next;
          busy_next   = 1'b1;
          cnt_next    = 4'd0;
          if (first_valid) begin
            sel_next   = first_ch;
            en_n_next  = 1'b0;
            state_next = DWELL;
          end else begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = FINISH;
          end
        end
      end

      DWELL: begin
        if (abort) begin
          en_n_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == SETTLE) begin
          shadow_next[sel_reg] = mux_out;
          if (next_valid) begin
            sel_next = next_ch;
            cnt_next = 4'd0;
          end else begin
            en_n_next  = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = FINISH;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      default: begin
        en_n_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      sel_reg      <= 3'd0;
      en_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      snapshot_reg <= 8'd0;
      changed_reg  <= 8'd0;
      shadow_reg   <= 8'd0;
      mask_q_reg   <= 8'd0;
      cnt_reg      <= 4'd0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      en_n_reg     <= en_n_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      snapshot_reg <= snapshot_next;
      changed_reg  <= changed_next;
      shadow_reg   <= shadow_next;
      mask_q_reg   <= mask_q_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign mux_sel      = sel_reg;
  assign mux_enable_n = en_n_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign snapshot     = snapshot_reg;
  assign changed      = changed_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 74151 source model.
module tb_mux_scan_ctrl;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] mask;
  logic [2:0] mux_sel;
  logic       mux_enable_n;
  logic       mux_out;
  logic       busy;
  logic       done;
  logic [7:0] snapshot;
  logic [7:0] changed;
  logic [7:0] src;

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .mask         (mask),
    .mux_sel      (mux_sel),
    .mux_enable_n (mux_enable_n),
    .mux_out      (mux_out),
    .busy         (busy),
    .done         (done),
    .snapshot     (snapshot),
    .changed      (changed)
  );

  // Disabled 74151 drives Y low.
  assign mux_out = mux_enable_n ? 1'b0 : src[mux_sel];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_scan(input logic [7:0] m, input logic [7:0] s);
    mask  = m;
    src   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Channels under test are contiguous from 0, so with D=2 the expected select is c/2.
  task automatic wait_done(input string tag, input int exp_cyc);
    int got  = -1;
    int errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got = c;
        break;
      end
      if (int'(mux_sel) != c / 2 || mux_enable_n || !busy) errs++;
      tick();
    end
    check({tag, "_steps"}, errs, 0);
    check({tag, "_done_cyc"}, got, exp_cyc);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_en_n_at_done"}, int'(mux_enable_n), 1);
  endtask

  task automatic finish_check(input string tag, input logic [7:0] exp_snap, input logic [7:0] exp_chg);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_snapshot"}, int'(snapshot), int'(exp_snap));
    check({tag, "_changed"}, int'(changed), int'(exp_chg));
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mask    = 8'h00;
    src     = 8'h00;
    #12;
    check("rst_sel", int'(mux_sel), 0);
    check("rst_en_n", int'(mux_enable_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_snapshot", int'(snapshot), 0);
    check("rst_changed", int'(changed), 0);
    reset_n = 1'b1;
    tick();

    start_scan(8'h00, 8'hA5);
    wait_done("scan1", 16);
    finish_check("scan1", 8'hA5, 8'hA5);

    start_scan(8'h00, 8'hA4);
    wait_done("scan2", 16);
    finish_check("scan2", 8'hA4, 8'h01);

    start_scan(8'h00, 8'hFF);
    wait_done("scan3", 16);
    finish_check("scan3", 8'hFF, 8'h5B);

    start_scan(8'hF0, 8'h0F);
    wait_done("mask_f0_a", 8);
    finish_check("mask_f0_a", 8'hFF, 8'h00);

    start_scan(8'hF0, 8'h05);
    wait_done("mask_f0_b", 8);
    finish_check("mask_f0_b", 8'hF5, 8'h0A);

    start_scan(8'hFF, 8'h00);
    wait_done("mask_ff", 0);
    finish_check("mask_ff", 8'hF5, 8'h00);

    // Abort on channel 3, with a stray start while busy beforehand.
    start_scan(8'h00, 8'h00);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_on_ch3", int'(mux_sel), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_en_n", int'(mux_enable_n), 1);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    check("abort_snapshot", int'(snapshot), 'hF5);
    check("abort_changed", int'(changed), 'h00);

    // Asynchronous reset mid-dwell.
    start_scan(8'h00, 8'hFF);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sel", int'(mux_sel), 0);
    check("arst_en_n", int'(mux_enable_n), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_snapshot", int'(snapshot), 0);
    check("arst_changed", int'(changed), 0);
    #3;
    reset_n = 1'b1;
    tick();

    // Back-to-back: start held in the done cycle.
    start_scan(8'h00, 8'h3C);
    wait_done("b2b_first", 16);
    start = 1'b1;
    finish_check("b2b_first", 8'h3C, 8'h3C);
    start = 1'b0;
    src   = 8'hC3;
    check("b2b_busy", int'(busy), 1);
    check("b2b_en_n", int'(mux_enable_n), 0);
    check("b2b_sel", int'(mux_sel), 0);
    wait_done("b2b_second", 16);
    finish_check("b2b_second", 8'hC3, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
